// File: rtl/ysyx_23060332_pkg.sv
// ysyx_23060332_pkg: shared widths, reset vector, response codes and IFU state encoding
package ysyx_23060332_pkg;
  localparam int INST_ADDR_BUS = 32;
  localparam int INST_BUS = 32;
  localparam logic [31:0] DEF_RESET_PC = 32'h8000_0000;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  typedef enum logic [1:0] {IFU_REQ, IFU_WAIT, IFU_HOLD} ifu_state_e;
endpackage

// File: rtl/ysyx_23060332_ifu.sv
// ysyx_23060332_ifu: instruction fetch unit issuing word reads and holding the result for decode
module ysyx_23060332_ifu
  import ysyx_23060332_pkg::*;
#(
  parameter int ADDR_W = INST_ADDR_BUS,
  parameter int INST_W = INST_BUS,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_arvalid,
  input  logic              mem_arready,
  output logic [ADDR_W-1:0] mem_araddr,
  input  logic              mem_rvalid,
  output logic              mem_rready,
  input  logic [INST_W-1:0] mem_rdata,
  input  logic [1:0]        mem_rresp,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] pc,
  output logic              inst_err,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr
);
  ifu_state_e state, state_nx;
  logic [ADDR_W-1:0] fetch_pc, fetch_nx, req_pc, pc_q, tgt;
  logic [INST_W-1:0] inst_q;
  logic kill, kill_nx, err_q, rst_q, cap, unused_lsb;
  // req_pc freezes the bus address while a redirect retargets fetch_pc;
  // rst_q keeps the request off the bus through the cycle in which rst is released
  assign tgt = {redirect_addr[ADDR_W-1:2], 2'b00};
  assign unused_lsb = ^redirect_addr[1:0];
  assign mem_arvalid = state == IFU_REQ && !rst_q;
  assign mem_araddr = req_pc;
  assign mem_rready = state == IFU_WAIT;
  assign inst_valid = state == IFU_HOLD;
  assign inst = inst_q;
  assign pc = pc_q;
  assign inst_err = err_q;
  // next state, next fetch address and kill tracking
  always_comb begin
    state_nx = state;
    fetch_nx = redirect_valid ? tgt : fetch_pc;
    kill_nx = kill | redirect_valid;
    cap = 1'b0;
    case (state)
      IFU_REQ: state_nx = mem_arvalid && mem_arready ? IFU_WAIT : IFU_REQ;
      IFU_WAIT: if (mem_rvalid) begin
        kill_nx = 1'b0;
        cap = !kill && !redirect_valid;
        state_nx = cap ? IFU_HOLD : IFU_REQ;
      end
      IFU_HOLD: begin
        kill_nx = 1'b0;
        if (redirect_valid || inst_ready) begin
          state_nx = IFU_REQ;
          fetch_nx = redirect_valid ? tgt : fetch_pc + ADDR_W'(4);
        end
      end
      default: state_nx = IFU_REQ;
    endcase
  end
  // state, address and held-instruction registers
  always_ff @(posedge clk) begin
    rst_q <= rst;
    if (rst) begin
      state <= IFU_REQ;
      fetch_pc <= RESET_PC;
      req_pc <= RESET_PC;
      kill <= 1'b0;
      inst_q <= '0;
      pc_q <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nx;
      fetch_pc <= fetch_nx;
      kill <= kill_nx;
      if (state != IFU_REQ && state_nx == IFU_REQ) req_pc <= fetch_nx;
      if (cap) begin
        inst_q <= mem_rdata;
        pc_q <= fetch_pc;
        err_q <= mem_rresp != RESP_OKAY;
      end
    end
  end
endmodule
